truth_table_checker: RTL and testbench

// Sequential response checker for the small combinational gate netlists (AND/OR/NOT

---
 rtl/truth_table_checker.sv | 146 ++++++++++++++
 tb/tb_truth_table_checker.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// truth_table_checker
// Walks every input combination of a small gate netlist, lets each vector settle,
// samples the netlist output and compares it with an expected truth table.
// Reports the mismatch count, the first failing vector and an overall pass flag.
module truth_table_checker #(
    parameter int                 N_IN      = 3,
    parameter int                 SETTLE    = 1,
    parameter logic [2**N_IN-1:0] EXP_TABLE = 8'h22
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_idx,
    output logic            first_fail_valid
);

    // Settle counter only has to hold SETTLE-1; keep at least one bit.
    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int              ERR_W       = N_IN + 1;
    localparam logic [N_IN-1:0] LAST_IDX    = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0] MAX_ERR    = ERR_W'(2**N_IN);
    localparam logic [SW-1:0]   SETTLE_INIT = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [N_IN-1:0]  r_idx;
    logic [SW-1:0]    r_settle;
    logic [ERR_W-1:0] r_err;
    logic [N_IN-1:0]  r_ff_idx;
    logic             r_ff_valid;
    logic             r_pass;
    logic             r_done;

    state_t           w_state_next;
    logic [N_IN-1:0]  w_idx_next;
    logic [SW-1:0]    w_settle_next;
    logic [ERR_W-1:0] w_err_next;
    logic [ERR_W-1:0] w_err_plus;
    logic [N_IN-1:0]  w_ff_idx_next;
    logic             w_ff_valid_next;
    logic             w_pass_next;
    logic             w_done_next;
    logic             w_mismatch;

    // State and result registers; reset clears every visible output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_settle   <= '0;
            r_err      <= '0;
            r_ff_idx   <= '0;
            r_ff_valid <= 1'b0;
            r_pass     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_settle   <= w_settle_next;
            r_err      <= w_err_next;
            r_ff_idx   <= w_ff_idx_next;
            r_ff_valid <= w_ff_valid_next;
            r_pass     <= w_pass_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state and datapath: sweep vectors, count mismatches, flag completion.
    always_comb begin
        w_state_next    = r_state;
        w_idx_next      = r_idx;
        w_settle_next   = r_settle;
        w_err_next      = r_err;
        w_ff_idx_next   = r_ff_idx;
        w_ff_valid_next = r_ff_valid;
        w_pass_next     = r_pass;
        w_done_next     = 1'b0;
        // 4-state compare so an undriven or X output counts as a failure.
        w_mismatch      = (dut_out !== EXP_TABLE[r_idx]);
        w_err_plus      = r_err;
        if (w_mismatch && (r_err != MAX_ERR)) begin
            w_err_plus = r_err + ERR_W'(1);
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next    = S_WAIT;
                    w_idx_next      = '0;
                    w_settle_next   = SETTLE_INIT;
                    w_err_next      = '0;
                    w_ff_idx_next   = '0;
                    w_ff_valid_next = 1'b0;
                    w_pass_next     = 1'b0;
                end
            end
            S_WAIT: begin
                if (r_settle == '0) begin
                    w_state_next = S_CHECK;
                end else begin
                    w_settle_next = r_settle - SW'(1);
                end
            end
            S_CHECK: begin
                w_err_next = w_err_plus;
                if (w_mismatch && !r_ff_valid) begin
                    w_ff_idx_next   = r_idx;
                    w_ff_valid_next = 1'b1;
                end
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                    w_pass_next  = (w_err_plus == '0);
                end else begin
                    w_state_next  = S_WAIT;
                    w_idx_next    = r_idx + N_IN'(1);
                    w_settle_next = SETTLE_INIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign stim             = r_idx;
    assign busy             = (r_state == S_WAIT) || (r_state == S_CHECK);
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_idx   = r_ff_idx;
    assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: two instances (SETTLE=1 and SETTLE=3)
// driven against behavioural gate models; expected sweep results are queued at
// start and popped by per-instance monitors when done pulses.
module tb_truth_table_checker;

    localparam logic [7:0] EXP_DEF = 8'h22;   // out = ~B & C

    typedef struct {
        int err;
        int ffidx;
        int ffv;
        int pass;
    } exp_t;

    logic       clk;
    logic       rst0_n, rst1_n;
    logic       start0, start1;
    logic [2:0] stim0, stim1;
    logic       out0, out1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] err0, err1;
    logic [2:0] ffidx0, ffidx1;
    logic       ffv0, ffv1;

    int         mode0;
    logic [7:0] tbl0;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [2:0] trace0[$];
    logic [2:0] trace1[$];
    int         done_cnt0, done_cnt1;
    logic       prev_done0, prev_done1;

    int n_cmp;
    int n_bad;

    // Behavioural netlist under test: A=s[2], B=s[1], C=s[0].
    function automatic logic dut_fn(input int mode, input logic [7:0] tbl, input logic [2:0] s);
        case (mode)
            0:       return ~s[1] & s[0];
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return s[2] & s[1];
            default: return tbl[s];
        endcase
    endfunction

    function automatic int order_errs(input logic [2:0] tr[$], input int per);
        int bad;
        bad = 0;
        for (int k = 0; k < tr.size(); k++) begin
            if (int'(tr[k]) != k / per) bad++;
        end
        return bad;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    assign out0 = dut_fn(mode0, tbl0, stim0);
    assign out1 = dut_fn(0, 8'h00, stim1);

    truth_table_checker #(.N_IN(3), .SETTLE(1), .EXP_TABLE(8'h22)) dut0 (
        .clk(clk), .rst_n(rst0_n), .start(start0), .stim(stim0), .dut_out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_idx(ffidx0), .first_fail_valid(ffv0)
    );

    truth_table_checker #(.N_IN(3), .SETTLE(3), .EXP_TABLE(8'h22)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1), .stim(stim1), .dut_out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_idx(ffidx1), .first_fail_valid(ffv1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor for instance 0: record stim while busy, score the sweep on done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst0_n) begin
            trace0.delete();
            prev_done0 <= 1'b0;
        end else begin
            if (prev_done0) chk("done0_single_cycle", int'(done0), 0);
            prev_done0 <= done0;
            if (busy0) trace0.push_back(stim0);
            if (done0) begin
                done_cnt0 <= done_cnt0 + 1;
                if (q0.size() == 0) begin
                    chk("done0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    $display("dut0 sweep %0d: err=%0d ffidx=%0d ffv=%0d pass=%0d busy_cycles=%0d (exp err=%0d ffidx=%0d ffv=%0d pass=%0d)",
                             done_cnt0, err0, ffidx0, ffv0, pass0, trace0.size(), e.err, e.ffidx, e.ffv, e.pass);
                    chk("dut0_err_count", int'(err0), e.err);
                    chk("dut0_first_fail_valid", int'(ffv0), e.ffv);
                    if (e.ffv != 0) chk("dut0_first_fail_idx", int'(ffidx0), e.ffidx);
                    chk("dut0_pass", int'(pass0), e.pass);
                    chk("dut0_busy_at_done", int'(busy0), 0);
                    chk("dut0_busy_cycles", trace0.size(), 16);
                    chk("dut0_stim_order", order_errs(trace0, 2), 0);
                end
                trace0.delete();
            end
        end
    end

    // Monitor for instance 1 (SETTLE=3).
    always @(negedge clk) begin
        exp_t e;
        if (!rst1_n) begin
            trace1.delete();
            prev_done1 <= 1'b0;
        end else begin
            if (prev_done1) chk("done1_single_cycle", int'(done1), 0);
            prev_done1 <= done1;
            if (busy1) trace1.push_back(stim1);
            if (done1) begin
                done_cnt1 <= done_cnt1 + 1;
                if (q1.size() == 0) begin
                    chk("done1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    $display("dut1 sweep %0d: err=%0d ffidx=%0d ffv=%0d pass=%0d busy_cycles=%0d (exp err=%0d pass=%0d)",
                             done_cnt1, err1, ffidx1, ffv1, pass1, trace1.size(), e.err, e.pass);
                    chk("dut1_err_count", int'(err1), e.err);
                    chk("dut1_first_fail_valid", int'(ffv1), e.ffv);
                    chk("dut1_pass", int'(pass1), e.pass);
                    chk("dut1_busy_cycles", trace1.size(), 32);
                    chk("dut1_stim_order", order_errs(trace1, 4), 0);
                end
                trace1.delete();
            end
        end
    end

    // Reference model: compare the gate function with the expected table vector by vector.
    task automatic expect0(input int mode, input logic [7:0] tbl);
        exp_t e;
        logic [7:0] exp_tbl;
        logic eb, ab;
        e = '{err: 0, ffidx: 0, ffv: 0, pass: 0};
        exp_tbl = EXP_DEF;
        for (int i = 0; i < 8; i++) begin
            eb = exp_tbl[i];
            ab = dut_fn(mode, tbl, 3'(i));
            if (eb != ab) begin
                e.err++;
                if (e.ffv == 0) begin
                    e.ffv   = 1;
                    e.ffidx = i;
                end
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        q0.push_back(e);
    endtask

    task automatic wait_done(input int sel, input int target, input int budget, input string name);
        int n;
        n = 0;
        while (((sel == 0) ? done_cnt0 : done_cnt1) < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (((sel == 0) ? done_cnt0 : done_cnt1) < target)
            chk({name, "_timeout"}, (sel == 0) ? done_cnt0 : done_cnt1, target);
    endtask

    task automatic run0(input int mode, input logic [7:0] tbl, input string name);
        int target;
        mode0 = mode;
        tbl0  = tbl;
        expect0(mode, tbl);
        target = done_cnt0 + 1;
        start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        wait_done(0, target, 100, name);
        @(negedge clk); #1;
    endtask

    task automatic chk_zero0(input string name);
        chk(name, int'({stim0, busy0, done0, pass0, err0, ffidx0, ffv0}), 0);
    endtask

    initial begin
        int target;
        n_cmp = 0; n_bad = 0;
        done_cnt0 = 0; done_cnt1 = 0;
        rst0_n = 1'b0; rst1_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        mode0 = 0; tbl0 = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk_zero0("reset0_outputs");
        chk("reset1_outputs", int'({stim1, busy1, done1, pass1, err1, ffidx1, ffv1}), 0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk); #1;
        chk_zero0("idle0_outputs");

        // Correct netlist, stuck-at-0, stuck-at-1, wrong function A&B.
        run0(0, 8'h00, "correct");
        run0(1, 8'h00, "stuck0");
        run0(2, 8'h00, "stuck1");
        // DONE without start: results and last vector hold.
        repeat (5) @(negedge clk);
        #1;
        chk("hold_err_count", int'(err0), 6);
        chk("hold_pass", int'(pass0), 0);
        chk("hold_ffv", int'(ffv0), 1);
        chk("hold_stim", int'(stim0), 7);
        chk("hold_busy", int'(busy0), 0);
        run0(3, 8'h00, "and_ab");

        // Randomised wrong/right functions as arbitrary truth tables.
        for (int r = 0; r < 8; r++) begin
            run0(4, 8'($urandom_range(0, 255)), "random_tbl");
        end
        run0(4, EXP_DEF, "exact_tbl");

        // start held high: back-to-back sweeps, one done pulse each.
        mode0 = 0;
        expect0(0, 8'h00);
        expect0(0, 8'h00);
        target = done_cnt0 + 1;
        start0 = 1'b1;
        wait_done(0, target, 100, "held_first");
        @(negedge clk); #1;
        chk("held_restart_busy", int'(busy0), 1);
        chk("held_restart_stim", int'(stim0), 0);
        start0 = 1'b0;
        wait_done(0, target + 1, 100, "held_second");
        @(negedge clk); #1;

        // Reset during WAIT of vector 3 with a faulty netlist, then a clean sweep.
        mode0 = 2;
        expect0(2, 8'h00);
        start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (busy0 && stim0 == 3'd3) break;
            @(negedge clk); #1;
        end
        chk("reached_idx3", int'(stim0), 3);
        rst0_n = 1'b0;
        #1;
        chk_zero0("midsweep_reset_outputs");
        q0.delete();
        @(negedge clk); #1;
        rst0_n = 1'b1;
        @(negedge clk); #1;
        chk_zero0("after_reset_idle");
        run0(0, 8'h00, "post_reset_clean");
        chk("post_reset_pass", int'(pass0), 1);

        // SETTLE=3 instance with start re-pulsed mid-sweep.
        q1.push_back('{err: 0, ffidx: 0, ffv: 0, pass: 1});
        start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        wait_done(1, 1, 200, "settle3");
        repeat (40) @(negedge clk);
        #1;
        chk("settle3_done_count", done_cnt1, 1);
        chk("settle3_busy_idle", int'(busy1), 0);
        chk("settle3_queue_empty", q1.size(), 0);
        chk("dut0_queue_empty", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time limit expected finish");
        $fatal(1, "timeout");
    end

endmodule
